// File: rtl/camera_frame_reader_if.sv
// Wishbone master bus and pixel stream of the camera frame reader.
// The master modport is the reader side; the slave modport is memory plus pixel consumer.
interface camera_frame_reader_if;
    logic [13:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_eol;
    logic        pix_last;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output pix_data, pix_valid, pix_eol, pix_last,
        input  wbm_dat_i, wbm_ack_i, pix_ready
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  pix_data, pix_valid, pix_eol, pix_last,
        output wbm_dat_i, wbm_ack_i, pix_ready
    );
endinterface

// File: rtl/camera_frame_reader.sv
// Freezes camera writes, waits two vsyncs, reads a packed 12-bit frame over Wishbone
// and streams it out one RGB444 pixel at a time, then releases the VRAM flag.
module camera_frame_reader #(
    parameter int VRAM_WORDS = 6144,
    parameter int LINE_PIX   = 128
) (
    input  logic                         wb_clk_i,
    input  logic                         rstb,
    input  logic                         start,
    input  logic                         c_vsync,
    camera_frame_reader_if.master        bus,
    output logic                         busy,
    output logic                         done
);
    typedef enum logic [2:0] {
        IDLE, FREEZE, WAIT_VS, RD, UNPACK, RELEASE, FIN
    } state_t;

    state_t             state;
    logic               vs_s1, vs_s2, vs_prev;
    logic               vs_rise;
    logic [1:0]         vs_cnt;
    logic [13:0]        idx;
    logic [1:0]         slot;
    logic [2:0]         sub;
    logic [13:0]        pix_cnt;
    logic [95:0]        buffer;
    logic [7:0][11:0]   pix_arr;
    logic [13:0]        adr;
    logic [31:0]        dat;
    logic               we, cyc, stb, pix_valid;

    always_ff @(posedge wb_clk_i or negedge rstb) begin
        if (!rstb) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_s1   <= c_vsync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
        end
    end

    assign vs_rise = vs_s2 & ~vs_prev;

    always_ff @(posedge wb_clk_i or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            vs_cnt    <= '0;
            idx       <= '0;
            slot      <= '0;
            sub       <= '0;
            pix_cnt   <= '0;
            buffer    <= '0;
            adr       <= '0;
            dat       <= '0;
            we        <= 1'b0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= FREEZE;
                    busy    <= 1'b1;
                    idx     <= '0;
                    slot    <= '0;
                    sub     <= '0;
                    pix_cnt <= '0;
                    vs_cnt  <= '0;
                    cyc     <= 1'b1;
                    stb     <= 1'b1;
                    we      <= 1'b1;
                    adr     <= '0;
                    dat     <= 32'h0000_0001;
                end
                // Raising the read flag makes the camera stop writing VRAM.
                FREEZE: if (bus.wbm_ack_i) begin
                    cyc    <= 1'b0;
                    stb    <= 1'b0;
                    we     <= 1'b0;
                    dat    <= '0;
                    vs_cnt <= '0;
                    state  <= WAIT_VS;
                end
                WAIT_VS: if (vs_rise) begin
                    if (vs_cnt == 2'd1) begin
                        state <= RD;
                        idx   <= '0;
                        slot  <= '0;
                    end else begin
                        vs_cnt <= vs_cnt + 2'd1;
                    end
                end
                RD: begin
                    if (!cyc) begin
                        cyc <= 1'b1;
                        stb <= 1'b1;
                        adr <= {1'b1, idx[12:0]};
                    end else if (bus.wbm_ack_i) begin
                        cyc <= 1'b0;
                        stb <= 1'b0;
                        adr <= '0;
                        case (slot)
                            2'd0:    buffer[95:64] <= bus.wbm_dat_i;
                            2'd1:    buffer[63:32] <= bus.wbm_dat_i;
                            default: buffer[31:0]  <= bus.wbm_dat_i;
                        endcase
                        idx <= idx + 14'd1;
                        // Three words hold exactly eight 12-bit pixels.
                        if (slot == 2'd2) begin
                            slot      <= '0;
                            sub       <= '0;
                            pix_valid <= 1'b1;
                            state     <= UNPACK;
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end
                UNPACK: if (bus.pix_ready) begin
                    pix_cnt <= pix_cnt + 14'd1;
                    sub     <= sub + 3'd1;
                    if (sub == 3'd7) begin
                        pix_valid <= 1'b0;
                        if (idx == 14'(VRAM_WORDS)) begin
                            state <= RELEASE;
                            cyc   <= 1'b1;
                            stb   <= 1'b1;
                            we    <= 1'b1;
                            adr   <= '0;
                            dat   <= '0;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RELEASE: if (bus.wbm_ack_i) begin
                    cyc   <= 1'b0;
                    stb   <= 1'b0;
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // p0 sits in the top 12 bits, so pixel n lives in element 7-n.
    assign pix_arr = buffer;

    assign bus.wbm_adr_o = adr;
    assign bus.wbm_dat_o = dat;
    assign bus.wbm_we_o  = we;
    assign bus.wbm_cyc_o = cyc;
    assign bus.wbm_stb_o = stb;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_data  = pix_valid ? pix_arr[3'd7 - sub] : 12'd0;
    assign bus.pix_eol   = pix_valid &&
                           (({18'd0, pix_cnt} % 32'(LINE_PIX)) == 32'(LINE_PIX - 1));
    assign bus.pix_last  = pix_valid && (pix_cnt == 14'h3FFF);
endmodule

// File: tb/tb_camera_frame_reader.sv
// Random-data frame captures checked against a word-array model of VRAM and the
// expected Wishbone access sequence, including backpressure, slow acks and mid-frame reset.
module tb_camera_frame_reader;
    localparam int VW   = 6144;
    localparam int NPIX = VW * 32 / 12;

    typedef struct packed {
        logic        we;
        logic [13:0] adr;
        logic [31:0] dat;
    } acc_t;

    logic wb_clk_i = 1'b0;
    logic rstb = 1'b0;
    logic start = 1'b0;
    logic c_vsync = 1'b0;
    logic busy, done;

    camera_frame_reader_if bus();

    camera_frame_reader #(.VRAM_WORDS(VW), .LINE_PIX(128)) dut (
        .wb_clk_i (wb_clk_i),
        .rstb     (rstb),
        .start    (start),
        .c_vsync  (c_vsync),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [VW];
    acc_t        exp_q [$];

    // responder state
    bit          hold_ack = 0, waiting = 0, freeze_acked = 0;
    int          slow_left = 0, wcnt = 0, cur_delay = 0, vs_seen = 0, frame_reads = 0;
    acc_t        cur;
    logic [13:0] first_rd, last_rd, last_wr_adr;
    logic [31:0] last_wr_dat;

    // pixel checker state
    int          fid = 0, seen_fid = 0, pk = 0, eol_tot = 0, last_tot = 0, done_cnt = 0;
    int          stall_left = 0;
    bit          stall_pin = 0, stalled = 0, done_prev = 0;
    logic [11:0] got [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_pix(input int k);
        logic [95:0] grp;
        int g, j;
        g = k / 8;
        j = k % 8;
        grp = {mem[3*g], mem[3*g+1], mem[3*g+2]};
        return grp[95 - 12*j -: 12];
    endfunction

    task automatic plan_frame();
        exp_q.delete();
        exp_q.push_back('{1'b1, 14'h0000, 32'h1});
        for (int i = 0; i < VW; i++) exp_q.push_back('{1'b0, 14'(14'h2000 + i), 32'h0});
        exp_q.push_back('{1'b1, 14'h0000, 32'h0});
    endtask

    task automatic ack_now();
        acc_t e;
        int   a;
        waiting = 0;
        bus.wbm_ack_i = 1'b1;
        a = int'(cur.adr) - 'h2000;
        bus.wbm_dat_i = (!cur.we && a >= 0 && a < VW) ? mem[a] : 32'h0;
        if (slow_left > 0) slow_left--;
        if (exp_q.size() == 0) chk("wb_unexpected_access", cur, 0);
        else begin
            e = exp_q.pop_front();
            chk("wb_access", cur, e);
        end
        if (cur.we) begin
            last_wr_adr = cur.adr;
            last_wr_dat = cur.dat;
            if (cur.dat == 32'h1) freeze_acked = 1;
        end else begin
            if (frame_reads == 0) first_rd = cur.adr;
            last_rd = cur.adr;
            frame_reads++;
        end
    endtask

    // Wishbone slave: one access at a time, ack after cur_delay extra wait cycles
    initial begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (!rstb) begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_dat_i = '0;
                waiting = 0;
            end else if (bus.wbm_ack_i) begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_dat_i = '0;
                chk("wb_drop_after_ack",
                    {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_dat_o}, 0);
            end else if (waiting) begin
                chk("wb_hold_stable",
                    {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o},
                    {1'b1, 1'b1, cur.we, cur.adr, cur.dat});
                wcnt++;
                if (!hold_ack && wcnt >= cur_delay) ack_now();
            end else if (bus.wbm_cyc_o || bus.wbm_stb_o) begin
                cur = '{bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o};
                waiting = 1;
                wcnt = 0;
                cur_delay = (slow_left > 0) ? 4 : 0;
                if (!cur.we && frame_reads == 0) chk("rd_before_2nd_vsync", vs_seen >= 2, 1);
                if (!hold_ack && cur_delay == 0) ack_now();
            end
        end
    end

    // Pixel consumer and per-cycle compare against the model
    initial begin
        bus.pix_ready = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (fid != seen_fid) begin
                seen_fid = fid; pk = 0; stalled = 0; stall_left = 0;
                eol_tot = 0; last_tot = 0; done_cnt = 0;
            end
            if (done) begin
                done_cnt++;
                chk("done_one_cycle", done_prev, 0);
            end
            done_prev = done;
            if (rstb && bus.pix_valid) begin
                chk("pix_during_bus", bus.wbm_cyc_o, 0);
                if (pk >= NPIX) chk("pix_overrun", pk, NPIX - 1);
                else begin
                    chk("pix_data", bus.pix_data, exp_pix(pk));
                    chk("pix_eol", bus.pix_eol, (pk % 128) == 127);
                    chk("pix_last", bus.pix_last, pk == NPIX - 1);
                end
                if (stall_pin && pk == 3 && !stalled) begin
                    stalled = 1;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    bus.pix_ready = 1'b0;
                    chk("stall_pix3", bus.pix_data, 12'hABC);
                end else if (pk < 512) bus.pix_ready = ($urandom_range(0, 3) != 0);
                else bus.pix_ready = 1'b1;
                if (bus.pix_ready) begin
                    if (pk < 8) got[pk] = bus.pix_data;
                    if (bus.pix_eol) eol_tot++;
                    if (bus.pix_last) last_tot++;
                    pk++;
                end
            end else begin
                bus.pix_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wb_clk_i);
            c_vsync = 1'b1;
            vs_seen++;
            repeat (3) @(negedge wb_clk_i);
            c_vsync = 1'b0;
            repeat (6) @(negedge wb_clk_i);
        end
    endtask

    task automatic begin_frame(input bit freeze_pulse, input int slow);
        int t;
        fid++;
        plan_frame();
        freeze_acked = 0; vs_seen = 0; frame_reads = 0; slow_left = slow;
        @(negedge wb_clk_i); start = 1'b1;
        @(negedge wb_clk_i); start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (freeze_pulse) begin
            // this edge lands while the freeze write is still waiting for ack
            c_vsync = 1'b1;
            repeat (2) @(negedge wb_clk_i);
            c_vsync = 1'b0;
        end
        t = 0;
        while (!freeze_acked && t < 1000) begin @(negedge wb_clk_i); t++; end
        chk("freeze_ack_seen", freeze_acked, 1);
        repeat (10) @(negedge wb_clk_i);
        vs_pulses(2);
    endtask

    task automatic finish_frame();
        int t;
        repeat (300) @(negedge wb_clk_i);
        start = 1'b1;
        @(negedge wb_clk_i); start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 60000) begin @(negedge wb_clk_i); t++; end
        repeat (4) @(negedge wb_clk_i);
        chk("frame_done_count", done_cnt, 1);
        chk("pix_count", pk, NPIX);
        chk("eol_count", eol_tot, 128);
        chk("last_count", last_tot, 1);
        chk("first_rd_adr", first_rd, 14'h2000);
        chk("last_rd_adr", last_rd, 14'h37FF);
        chk("read_count", frame_reads, VW);
        chk("release_wr", {last_wr_adr, last_wr_dat}, {14'h0, 32'h0});
        chk("accesses_left", exp_q.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        logic [11:0] lit [8];
        int t, bad;
        lit = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h013, 12'h579, 12'hBDF};
        foreach (mem[i]) mem[i] = $urandom;
        mem[0] = 32'h12345678; mem[1] = 32'h9ABCDEF0; mem[2] = 32'h13579BDF;
        for (int i = 0; i < 8; i++) chk("model_pin", exp_pix(i), lit[i]);

        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_wb_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 0);
        chk("rst_wb_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 0);
        chk("rst_pix", {bus.pix_valid, bus.pix_eol, bus.pix_last, bus.pix_data}, 0);
        rstb = 1'b1;
        repeat (3) @(negedge wb_clk_i);

        // Frame A: literal words up front, stall on pixel 3, start while busy
        stall_pin = 1;
        begin_frame(0, 0);
        finish_frame();
        for (int i = 0; i < 8; i++) chk("frameA_pix_lit", got[i], lit[i]);
        stall_pin = 0;

        // Frame B: reset while a read is waiting for ack
        fid++;
        begin_frame(0, 0);
        t = 0;
        while (frame_reads < 4 && t < 2000) begin @(negedge wb_clk_i); t++; end
        hold_ack = 1;
        t = 0;
        while (!(waiting && !cur.we) && t < 100) begin @(negedge wb_clk_i); t++; end
        chk("rd_outstanding", waiting && !cur.we, 1);
        @(negedge wb_clk_i);
        rstb = 1'b0;
        #1;
        chk("rst_mid_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pix_valid", bus.pix_valid, 0);
        exp_q.delete();
        repeat (3) @(negedge wb_clk_i);
        rstb = 1'b1;
        hold_ack = 0;
        bad = 0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (bus.wbm_cyc_o || busy) bad++;
        end
        chk("no_release_after_reset", bad, 0);

        // Frame C: fresh data, slow acks on the first accesses, vsync during freeze
        foreach (mem[i]) mem[i] = $urandom;
        begin_frame(1, 12);
        finish_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
